// File: rtl/risc_pkg.sv
// Shared definitions for the RISC pipeline: memory-port arbiter state and
// instruction field positions used by the decode and hazard logic.
package risc_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    // Instruction field positions and widths.
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 7;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_W   = 3;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_W   = 7;
    localparam int REG_IDX_W  = 5;

endpackage

// File: rtl/mem_port_arbiter_streak_cnt.sv
// Saturating count of consecutive data grants made while fetch was waiting.
module arb_streak_cnt #(
    parameter int MAX_CNT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam int CNT_W = $clog2(MAX_CNT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == CNT_W'(MAX_CNT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified memory between fetch and the memory stage,
// one req/ack transaction at a time, with bounded fetch starvation.
module mem_port_arbiter
    import risc_pkg::*;
#(
    parameter int N             = 10,
    parameter int MAX_DM_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [N-1:0]      if_addr_i,
    input  logic              if_flush_i,
    output logic [WORD_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [N-1:0]      dm_addr_i,
    input  logic [WORD_W-1:0] dm_wdata_i,
    output logic [WORD_W-1:0] dm_rdata_o,
    output logic              dm_valid_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [N-1:0]      mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    input  logic [WORD_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stallF_req_o,
    output logic              stallM_req_o
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              drop_q;
    logic              drop_d;
    logic              mem_we_q;
    logic              mem_we_d;
    logic [N-1:0]      mem_addr_q;
    logic [N-1:0]      mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q;
    logic [WORD_W-1:0] mem_wdata_d;

    logic grant_f;
    logic grant_d;
    logic streak_inc;
    logic streak_clr;
    logic streak_at_max;

    arb_streak_cnt #(
        .MAX_CNT (MAX_DM_STREAK)
    ) u_streak (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_i    (streak_inc),
        .clr_i    (streak_clr),
        .at_max_o (streak_at_max)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_f     = 1'b0;
        grant_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                // A redirecting fetch is never granted; data wins unless fetch has starved long enough.
                grant_f = if_req_i && !if_flush_i && (!dm_req_i || streak_at_max);
                grant_d = dm_req_i && !grant_f;
                if (grant_f) begin
                    state_d     = FETCH;
                    mem_addr_d  = if_addr_i;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = '0;
                end else if (grant_d) begin
                    state_d     = DATA;
                    mem_addr_d  = dm_addr_i;
                    mem_we_d    = dm_we_i;
                    mem_wdata_d = dm_wdata_i;
                end
            end
            FETCH: begin
                // The memory cannot cancel, so a flushed fetch runs to ack with its result dropped.
                if (mem_ack_i) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end else if (if_flush_i) begin
                    drop_d = 1'b1;
                end
            end
            DATA: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
        endcase

        streak_inc = grant_d && if_req_i;
        streak_clr = grant_f || (grant_d && !if_req_i);
    end

    always_comb begin
        mem_req_o   = (state_q != IDLE);
        mem_we_o    = mem_we_q;
        mem_addr_o  = mem_addr_q;
        mem_wdata_o = mem_wdata_q;

        // A flush in the ack cycle itself also suppresses the fetch result.
        if_valid_o = mem_ack_i && (state_q == FETCH) && !drop_q && !if_flush_i;
        dm_valid_o = mem_ack_i && (state_q == DATA);
        if_rdata_o = if_valid_o ? mem_rdata_i : '0;
        dm_rdata_o = dm_valid_o ? mem_rdata_i : '0;

        stallF_req_o = if_req_i && !if_valid_o && !if_flush_i;
        stallM_req_o = dm_req_i && !dm_valid_o;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int N   = 10;
    localparam int MAX = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req_i;
    logic [N-1:0]  if_addr_i;
    logic          if_flush_i;
    logic [31:0]   if_rdata_o;
    logic          if_valid_o;
    logic          dm_req_i;
    logic          dm_we_i;
    logic [N-1:0]  dm_addr_i;
    logic [31:0]   dm_wdata_i;
    logic [31:0]   dm_rdata_o;
    logic          dm_valid_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [N-1:0]  mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;
    logic          mem_ack_i;
    logic          stallF_req_o;
    logic          stallM_req_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N(N), .MAX_DM_STREAK(MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_flush_i   (if_flush_i),
        .if_rdata_o   (if_rdata_o),
        .if_valid_o   (if_valid_o),
        .dm_req_i     (dm_req_i),
        .dm_we_i      (dm_we_i),
        .dm_addr_i    (dm_addr_i),
        .dm_wdata_i   (dm_wdata_i),
        .dm_rdata_o   (dm_rdata_o),
        .dm_valid_o   (dm_valid_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i),
        .stallF_req_o (stallF_req_o),
        .stallM_req_o (stallM_req_o)
    );

    int tests = 0;
    int fails = 0;

    // Memory model
    logic [31:0] mem [0:1023];
    int age = 0;
    int lat = 0;
    int fixed_lat = 0;
    bit prev_req = 0;
    bit prev_ack = 0;
    bit spurious = 0;

    // Reference model: who owns the port and what was latched at grant
    int          m_owner;     // 0 none, 1 fetch, 2 data
    int          m_streak;
    bit          m_drop;
    logic [N-1:0] m_addr;
    bit          m_we;
    logic [31:0] m_wdata;
    bit          known = 0;

    // Values observed in the most recent step
    bit          s_if_v, s_dm_v, s_mem_req, s_mem_we, s_stallF;
    logic [31:0] s_if_rd, s_dm_rd, s_mem_wdata;
    logic [N-1:0] s_mem_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input bit ack);
        bit exp_if_v;
        bit exp_dm_v;
        exp_if_v = ack && (m_owner == 1) && !m_drop && !if_flush_i;
        exp_dm_v = ack && (m_owner == 2);
        chk("mem_req", 32'(mem_req_o), 32'(m_owner != 0));
        chk("mem_we", 32'(mem_we_o), 32'(m_we));
        chk("mem_addr", 32'(mem_addr_o), 32'(m_addr));
        chk("mem_wdata", mem_wdata_o, m_wdata);
        chk("if_valid", 32'(if_valid_o), 32'(exp_if_v));
        chk("dm_valid", 32'(dm_valid_o), 32'(exp_dm_v));
        chk("if_rdata", if_rdata_o, exp_if_v ? mem[m_addr] : 32'h0);
        if (!exp_dm_v) chk("dm_rdata_zero", dm_rdata_o, 32'h0);
        else if (!m_we) chk("dm_rdata", dm_rdata_o, mem[m_addr]);
        chk("stallF", 32'(stallF_req_o), 32'(if_req_i && !exp_if_v && !if_flush_i));
        chk("stallM", 32'(stallM_req_o), 32'(dm_req_i && !exp_dm_v));
    endtask

    task automatic model_update(input bit ack);
        bit fetch_ok;
        if (!rst_n) begin
            m_owner = 0; m_streak = 0; m_drop = 0;
            m_addr = '0; m_we = 0; m_wdata = '0;
            known = 1;
        end else if (m_owner == 0) begin
            fetch_ok = if_req_i && !if_flush_i;
            if (fetch_ok && (!dm_req_i || m_streak == MAX)) begin
                m_owner = 1; m_addr = if_addr_i; m_we = 0; m_wdata = '0;
                m_streak = 0;
            end else if (dm_req_i) begin
                m_owner = 2; m_addr = dm_addr_i; m_we = dm_we_i; m_wdata = dm_wdata_i;
                m_streak = if_req_i ? ((m_streak < MAX) ? m_streak + 1 : MAX) : 0;
            end
        end else if (ack) begin
            m_owner = 0;
            m_drop = 0;
        end else if (m_owner == 1 && if_flush_i) begin
            m_drop = 1;
        end
    endtask

    // One clock cycle: inputs already set by the caller at posedge+1.
    task automatic step();
        bit ack;
        if (mem_req_o !== 1'b1) begin
            age = 0;
        end else if (prev_req && !prev_ack) begin
            age++;
        end else begin
            age = 0;
            lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end
        ack = (mem_req_o === 1'b1) ? (age == lat) : spurious;
        mem_ack_i = ack;
        mem_rdata_i = (ack && mem_req_o === 1'b1 && mem_we_o === 1'b0) ? mem[mem_addr_o] : $urandom;
        #1;
        s_if_v = if_valid_o; s_dm_v = dm_valid_o; s_mem_req = mem_req_o;
        s_mem_we = mem_we_o; s_stallF = stallF_req_o; s_if_rd = if_rdata_o;
        s_dm_rd = dm_rdata_o; s_mem_addr = mem_addr_o; s_mem_wdata = mem_wdata_o;
        if (known) check_outputs(ack);
        prev_req = (mem_req_o === 1'b1);
        prev_ack = ack;
        if (ack && mem_req_o === 1'b1 && mem_we_o === 1'b1) mem[mem_addr_o] = mem_wdata_o;
        model_update(ack);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        int idx2;
        int vcount;
        bit we_seen;
        logic [31:0] rd;
        string obs;

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst_n = 0; if_req_i = 0; if_addr_i = '0; if_flush_i = 0;
        dm_req_i = 0; dm_we_i = 0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_ack_i = 0; mem_rdata_i = '0;
        @(posedge clk); #1;
        step();
        step();
        rst_n = 1;
        step();

        // Fetch only, one wait cycle
        fixed_lat = 1;
        mem[5] = 32'hC000_0001;
        if_req_i = 1; if_addr_i = 10'h005;
        idx = -1; rd = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k <= 1) chk("t1_stallF", 32'(s_stallF), 32'd1);
            if (k == 0) chk("t1_req_t0", 32'(s_mem_req), 32'd0);
            if (k == 1) chk("t1_req_t1", 32'(s_mem_req), 32'd1);
            if (s_if_v) begin idx = k; rd = s_if_rd; break; end
        end
        chk("t1_valid_cycle", 32'(idx), 32'd2);
        chk("t1_rdata", rd, 32'hC000_0001);
        if_req_i = 0;
        step();

        // Simultaneous requests, zero-wait store then fetch
        fixed_lat = 0;
        mem[10'h020] = 32'h0000_0013;
        if_req_i = 1; if_addr_i = 10'h020;
        dm_req_i = 1; dm_we_i = 1; dm_addr_i = 10'h010; dm_wdata_i = 32'hDEAD_BEEF;
        idx = -1; idx2 = -1; we_seen = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (s_dm_v && idx < 0) begin idx = k; we_seen = s_mem_we; dm_req_i = 0; dm_we_i = 0; end
            if (s_if_v) begin idx2 = k; break; end
        end
        chk("t2_dm_cycle", 32'(idx), 32'd1);
        chk("t2_mem_we", 32'(we_seen), 32'd1);
        chk("t2_if_cycle", 32'(idx2), 32'd3);
        chk("t2_store", mem[10'h010], 32'hDEAD_BEEF);
        if_req_i = 0;
        step();

        // Both held high: fetch is starved for at most MAX data grants
        if_req_i = 1; dm_req_i = 1; dm_we_i = 0;
        obs = "";
        for (int k = 0; k < 16; k++) begin
            step();
            if (s_if_v) obs = {obs, "F"};
            if (s_dm_v) obs = {obs, "D"};
        end
        chk("t3_order", 32'(obs == "DDDFDDDF"), 32'd1);
        if_req_i = 0; dm_req_i = 0;
        step();

        // Flush during a three-wait fetch
        fixed_lat = 3;
        if_req_i = 1; if_addr_i = 10'h007;
        vcount = 0;
        for (int k = 0; k < 6; k++) begin
            if_flush_i = (k == 1 || k == 2);
            step();
            if (k == 1 || k == 2) chk("t4_stallF_flush", 32'(s_stallF), 32'd0);
            if (k == 4) chk("t4_req_held", 32'(s_mem_req), 32'd1);
            if (s_if_v) vcount++;
        end
        chk("t4_no_valid", 32'(vcount), 32'd0);
        fixed_lat = 0;
        idx = -1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (s_if_v) begin idx = k; rd = s_if_rd; break; end
        end
        chk("t4_refetch_seen", 32'(idx >= 0), 32'd1);
        chk("t4_refetch_rdata", rd, mem[7]);
        if_req_i = 0;
        step();

        // Reset in the middle of a data access
        fixed_lat = 3;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 10'h030; dm_wdata_i = 32'h1111_2222;
        step();
        step();
        rst_n = 0;
        step();
        rst_n = 1; dm_req_i = 0;
        step();
        chk("t5_req", 32'(s_mem_req), 32'd0);
        chk("t5_addr", 32'(s_mem_addr), 32'd0);
        chk("t5_we", 32'(s_mem_we), 32'd0);
        chk("t5_wdata", s_mem_wdata, 32'd0);
        chk("t5_dm_valid", 32'(s_dm_v), 32'd0);
        fixed_lat = 0;
        mem[10'h030] = 32'hABCD_1234;
        dm_req_i = 1;
        idx = -1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (s_dm_v) begin idx = k; rd = s_dm_rd; dm_req_i = 0; break; end
        end
        chk("t5_after_cycle", 32'(idx), 32'd1);
        chk("t5_after_rdata", rd, 32'hABCD_1234);
        step();

        // Spurious ack while idle
        spurious = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6_if_valid", 32'(s_if_v), 32'd0);
            chk("t6_dm_valid", 32'(s_dm_v), 32'd0);
            chk("t6_req", 32'(s_mem_req), 32'd0);
        end
        spurious = 0;

        // Randomized traffic
        fixed_lat = -1;
        for (int k = 0; k < 1500; k++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            if_req_i   = ($urandom_range(0, 3) != 0);
            if_addr_i  = N'($urandom);
            if_flush_i = ($urandom_range(0, 9) == 0);
            dm_req_i   = ($urandom_range(0, 2) == 0);
            dm_we_i    = $urandom_range(0, 1) == 1;
            dm_addr_i  = N'($urandom);
            dm_wdata_i = $urandom;
            spurious   = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified instruction/data memory of the RISC pipeline between the fetch stage (IF) and the memory stage (MEM). Each requester gets a request/valid handshake. The arbiter grants one access at a time, runs a req/ack transaction on the memory port, and returns read data. It also raises stall requests that the hazard unit merges into stallF/stallD/flushE. Data accesses normally win; a streak counter bounds how long fetch can be starved.

## Interface
- `N`, 10, memory word-address width
- `MAX_DM_STREAK`, 3, consecutive data grants allowed while fetch waits (≥1)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low
- `if_req_i`  in  1  fetch access request
- `if_addr_i`  in  N  fetch word address (PC)
- `if_flush_i`  in  1  fetch redirect (pc_sel≠00); abandons current fetch
- `if_rdata_o`  out  32  fetched instruction
- `if_valid_o`  out  1  fetch complete this cycle
- `dm_req_i`  in  1  data access request
- `dm_we_i`  in  1  1 = store, 0 = load
- `dm_addr_i`  in  N  data word address
- `dm_wdata_i`  in  32  store data
- `dm_rdata_o`  out  32  load data
- `dm_valid_o`  out  1  data access complete this cycle
- `mem_req_o`  out  1  memory request, held until ack
- `mem_we_o`  out  1  memory write enable
- `mem_addr_o`  out  N  memory address
- `mem_wdata_o`  out  32  memory write data
- `mem_rdata_i`  in  32  memory read data, valid with ack
- `mem_ack_i`  in  1  one-cycle completion pulse
- `stallF_req_o`  out  1  fetch not served this cycle
- `stallM_req_o`  out  1  data access not served this cycle

## Operation
- FSM states: IDLE, FETCH, DATA.
- **IDLE** arbitration:
  - `dm_req_i` wins, unless `if_req_i` is pending and streak == MAX_DM_STREAK. In that case fetch wins.
  - No request: stay in IDLE.
  - `if_flush_i` high in IDLE blocks a fetch grant that cycle. A data request may still be granted.
- **Grant** (IDLE→FETCH/DATA edge): register address, we and wdata into `mem_addr_o`, `mem_we_o`, `mem_wdata_o`. Fetch grants force we = 0.
- `mem_req_o` = (state != IDLE). It stays high with stable addr/we/wdata until `mem_ack_i`.
- **On `mem_ack_i`** in FETCH/DATA: go to IDLE on the next edge.
  - `if_valid_o` / `dm_valid_o` are combinational: ack & (state matches) & not dropped.
  - `*_rdata_o` pass `mem_rdata_i` through. They are 0 when the matching valid is low.
  - Stores return `dm_valid_o` = 1; `dm_rdata_o` is don't-care.
- **Requester rule:** a requester samples valid at the edge and must deassert or replace req by the next cycle. Req still high in IDLE is a new access.
- **Streak counter** (width `$clog2(MAX_DM_STREAK+1)`):
  - +1 on a data grant while `if_req_i` is high, saturating.
  - Cleared on a fetch grant, or when `if_req_i` is low at a data grant.
- **Flush:** `if_flush_i` during FETCH sets a drop flag. The transaction still runs to ack, because the memory cannot cancel. `if_valid_o` is suppressed on that ack. The flag clears when leaving FETCH.
- **Stalls** (combinational):
  - `stallF_req_o` = `if_req_i` & ~`if_valid_o` & ~`if_flush_i`
  - `stallM_req_o` = `dm_req_i` & ~`dm_valid_o`
- **Reset** (synchronous, any state): next edge gives state IDLE, streak 0, drop 0. `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o` go to 0; valids and rdata go to 0. An in-flight memory transaction is abandoned; the memory model must tolerate `mem_req_o` dropping without ack.

## Timing
- Request seen in IDLE at cycle t: `mem_req_o` is high from cycle t+1.
- Zero-wait memory (ack in the same cycle as req): valid at t+1, total 2 cycles.
- Memory with L wait cycles: valid at t+1+L.
- Back-to-back throughput: one access per 2 cycles (mandatory IDLE cycle).
- Simultaneous requests in IDLE with streak < MAX: DATA granted; fetch is served next, at the earliest 2 cycles later.
- Ack in IDLE: ignored.
- Flush and ack in the same FETCH cycle: drop takes effect, `if_valid_o` = 0.

## Structure
- Shared package `risc_pkg`: state enum `arb_state_t` {IDLE, FETCH, DATA}; `WORD_W` = 32. Instruction field constants also belong there, next to the hazard unit's.
- One natural sub-module: `arb_streak_cnt`, the saturating streak counter with inc/clr/at_max.
- Everything else stays in a single always_ff + always_comb pair.

## Test plan
- Fetch only, addr 0x005, memory acks 1 cycle after req with rdata 0xC0000001 → `mem_req_o` at t+1, `if_valid_o` at t+2 with rdata 0xC0000001, `stallF_req_o` = 1 in cycles t..t+1.
- Both requesting from t, streak 0, zero-wait store dm_addr 0x010 wdata 0xDEADBEEF → DATA granted, `mem_we_o` = 1, `dm_valid_o` at t+1; fetch granted at t+2, `if_valid_o` at t+3.
- MAX_DM_STREAK = 3; `dm_req_i` and `if_req_i` held high, zero-wait → grant order D, D, D, F, D…; streak resets after F.
- Flush during a 3-wait-cycle fetch → `mem_req_o` held to ack, `if_valid_o` never asserts, `stallF_req_o` = 0 while flush is high; the next fetch proceeds normally.
- Reset asserted mid-DATA → next edge: all outputs 0, state IDLE. A request after release is granted normally.
- Ack arriving in IDLE (spurious) → no valid, no state change.
